// File: rtl/amba3_apb_sram_slave_pkg.sv
// ---------------------------------------------------------------------------
// amba3_apb_sram_slave_pkg
// Shared types and helpers for the APB SRAM completer.
//   apb_slave_state_e : handshake FSM states
//   addr_t / data_t   : default-width APB address and data words
//   addr_base()       : number of byte-offset bits in one data word
// ---------------------------------------------------------------------------
package amba3_apb_sram_slave_pkg;

  localparam int unsigned APB_ADDR_SIZE = 32;
  localparam int unsigned APB_DATA_SIZE = 32;
  localparam int unsigned WAIT_CNT_W    = 4;   // holds WAIT_CYCLES 0..15

  typedef logic [APB_ADDR_SIZE-1:0] addr_t;
  typedef logic [APB_DATA_SIZE-1:0] data_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } apb_slave_state_e;

  function automatic int unsigned addr_base(input int unsigned data_size);
    return $clog2(data_size / 8);
  endfunction

endpackage

// File: rtl/amba3_apb_sram_slave_if.sv
// ---------------------------------------------------------------------------
// amba3_apb_if
// AMBA 3 APB signal bundle (clock and reset travel as plain ports).
//   paddr/psel/penable/pwrite/pwdata : requester -> completer
//   prdata/pready/pslverr            : completer -> requester
// ---------------------------------------------------------------------------
interface amba3_apb_if #(
  parameter int unsigned ADDR_SIZE = 32,
  parameter int unsigned DATA_SIZE = 32
) ();

  logic [ADDR_SIZE-1:0] paddr;
  logic                 psel;
  logic                 penable;
  logic                 pwrite;
  logic [DATA_SIZE-1:0] pwdata;
  logic [DATA_SIZE-1:0] prdata;
  logic                 pready;
  logic                 pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/amba3_apb_sram_slave_array.sv
// ---------------------------------------------------------------------------
// amba3_apb_sram_array
// MEM_DEPTH x DATA_SIZE flop array, cleared by async reset.
//   clk_i, rst_n_i     : clock, async active-low clear
//   we_i/waddr_i/wdata_i : synchronous write port
//   raddr_i/rdata_o    : combinational read port
// ---------------------------------------------------------------------------
module amba3_apb_sram_array #(
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned IDX_W     = $clog2(MEM_DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 we_i,
  input  logic [IDX_W-1:0]     waddr_i,
  input  logic [DATA_SIZE-1:0] wdata_i,
  input  logic [IDX_W-1:0]     raddr_i,
  output logic [DATA_SIZE-1:0] rdata_o
);

  logic [DATA_SIZE-1:0] mem_q [MEM_DEPTH];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mem_q <= '{default: '0};
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/amba3_apb_sram_slave.sv
// ---------------------------------------------------------------------------
// amba3_apb_sram_slave
// APB completer in front of a word-addressed register memory, with a fixed
// number of wait states and PSLVERR on out-of-window or misaligned accesses.
//   pclk     : APB clock
//   preset_n : async active-low reset
//   apb      : amba3_apb_if.slave bundle
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no transfer; waits for a setup phase (psel & !penable)
// ST_ACCESS | access phase; wait counter runs down, pready on terminal count
// ST_DONE   | cycle after completion; outputs cleared, may take a new setup
// ---------------------------------------------------------------------------
module amba3_apb_sram_slave
  import amba3_apb_sram_slave_pkg::*;
#(
  parameter int unsigned     ADDR_SIZE   = 32,
  parameter int unsigned     DATA_SIZE   = 32,
  parameter int unsigned     MEM_DEPTH   = 256,
  parameter longint unsigned MEM_BASE    = 'h0000,
  parameter int unsigned     WAIT_CYCLES = 0
) (
  input logic        pclk,
  input logic        preset_n,
  amba3_apb_if.slave apb
);

  localparam int unsigned ADDR_BASE = addr_base(DATA_SIZE);
  localparam int unsigned IDX_W     = $clog2(MEM_DEPTH);
  localparam logic [ADDR_SIZE:0] WIN_LO    = (ADDR_SIZE+1)'(MEM_BASE);
  localparam logic [ADDR_SIZE:0] WIN_BYTES = (ADDR_SIZE+1)'(64'(MEM_DEPTH) * 64'(DATA_SIZE / 8));
  localparam logic [ADDR_SIZE-1:0] ALIGN_MASK = ADDR_SIZE'((64'd1 << ADDR_BASE) - 64'd1);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES);

  if (64'(MEM_BASE) + 64'(MEM_DEPTH) * 64'(DATA_SIZE / 8) > (64'd1 << ADDR_SIZE)) begin : g_win_chk
    $error("memory window runs past the top of the address space");
  end
  if (WAIT_CYCLES > 15) begin : g_wait_chk
    $error("WAIT_CYCLES must be 0..15");
  end

  apb_slave_state_e      state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  write_q, write_d;
  logic                  err_q, err_d;
  logic [DATA_SIZE-1:0]  wdata_q, wdata_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [DATA_SIZE-1:0]  prdata_q, prdata_d;

  logic                  mem_we;
  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_SIZE-1:0]  mem_rdata;

  // Window check via subtraction: the extra MSB is the borrow, so no
  // comparison ever degenerates to a constant when MEM_BASE is zero.
  logic [ADDR_SIZE+1:0] win_off;
  logic                 in_range, aligned, new_err, setup;
  logic [IDX_W-1:0]     new_idx;

  assign win_off  = {2'b00, apb.paddr} - {1'b0, WIN_LO};
  assign in_range = !win_off[ADDR_SIZE+1] && (win_off[ADDR_SIZE:0] < WIN_BYTES);
  assign aligned  = ((apb.paddr & ALIGN_MASK) == '0);
  assign new_err  = !(in_range && aligned);
  assign new_idx  = apb.paddr[ADDR_BASE +: IDX_W];
  assign setup    = apb.psel && !apb.penable;

  // Outside ACCESS the read port follows the incoming address so that a
  // zero-wait read can load prdata on the setup edge.
  assign rd_idx = (state_q == ST_ACCESS) ? idx_q : new_idx;

  amba3_apb_sram_array #(
    .DATA_SIZE (DATA_SIZE),
    .MEM_DEPTH (MEM_DEPTH),
    .IDX_W     (IDX_W)
  ) u_array (
    .clk_i   (pclk),
    .rst_n_i (preset_n),
    .we_i    (mem_we),
    .waddr_i (idx_q),
    .wdata_i (wdata_q),
    .raddr_i (rd_idx),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      wdata_q   <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      write_q   <= write_d;
      err_q     <= err_d;
      wdata_q   <= wdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    write_d   = write_q;
    err_d     = err_q;
    wdata_d   = wdata_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    mem_we    = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (setup) begin
          state_d = ST_ACCESS;
          cnt_d   = WAIT_LOAD;
          idx_d   = new_idx;
          write_d = apb.pwrite;
          err_d   = new_err;
          wdata_d = apb.pwdata;
          if (WAIT_CYCLES == 0) begin
            pready_d  = 1'b1;
            pslverr_d = new_err;
            prdata_d  = (!apb.pwrite && !new_err) ? mem_rdata : '0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ACCESS: begin
        if (!apb.psel) begin
          state_d = ST_IDLE;
        end else if (pready_q) begin
          if (apb.penable) begin
            mem_we  = write_q && !err_q;
            state_d = ST_DONE;
          end else begin
            // penable dropped with the response up: hold it until seen
            pready_d  = 1'b1;
            pslverr_d = pslverr_q;
            prdata_d  = prdata_q;
          end
        end else begin
          cnt_d = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
          if (cnt_q <= WAIT_CNT_W'(1)) begin
            pready_d  = 1'b1;
            pslverr_d = err_q;
            prdata_d  = (!write_q && !err_q) ? mem_rdata : '0;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign apb.prdata  = prdata_q;
  assign apb.pready  = pready_q;
  assign apb.pslverr = pslverr_q;

endmodule

// File: tb/tb_amba3_apb_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_amba3_apb_sram_slave
// Three completers (WAIT_CYCLES 0, 2, 3) share one APB driver; psel is
// steered to the selected instance and its responses are muxed back.
// ---------------------------------------------------------------------------
module tb_amba3_apb_sram_slave;
  import amba3_apb_sram_slave_pkg::*;

  logic pclk = 1'b0;
  logic preset_n = 1'b0;
  always #5 pclk = ~pclk;

  int    t_sel = 0;
  addr_t t_paddr = '0;
  logic  t_psel = 1'b0, t_penable = 1'b0, t_pwrite = 1'b0;
  data_t t_pwdata = '0;

  data_t r_prdata;
  logic  r_pready, r_pslverr;

  int n_tests = 0;
  int n_fail  = 0;

  amba3_apb_if apb0 ();
  amba3_apb_if apb1 ();
  amba3_apb_if apb2 ();

  assign apb0.paddr = t_paddr;  assign apb1.paddr = t_paddr;  assign apb2.paddr = t_paddr;
  assign apb0.pwrite = t_pwrite; assign apb1.pwrite = t_pwrite; assign apb2.pwrite = t_pwrite;
  assign apb0.pwdata = t_pwdata; assign apb1.pwdata = t_pwdata; assign apb2.pwdata = t_pwdata;
  assign apb0.penable = t_penable; assign apb1.penable = t_penable; assign apb2.penable = t_penable;
  assign apb0.psel = t_psel && (t_sel == 0);
  assign apb1.psel = t_psel && (t_sel == 1);
  assign apb2.psel = t_psel && (t_sel == 2);

  assign r_prdata  = (t_sel == 0) ? apb0.prdata  : (t_sel == 1) ? apb1.prdata  : apb2.prdata;
  assign r_pready  = (t_sel == 0) ? apb0.pready  : (t_sel == 1) ? apb1.pready  : apb2.pready;
  assign r_pslverr = (t_sel == 0) ? apb0.pslverr : (t_sel == 1) ? apb1.pslverr : apb2.pslverr;

  amba3_apb_sram_slave #(.WAIT_CYCLES(0)) u_dut0 (.pclk(pclk), .preset_n(preset_n), .apb(apb0));
  amba3_apb_sram_slave #(.WAIT_CYCLES(2)) u_dut1 (.pclk(pclk), .preset_n(preset_n), .apb(apb1));
  amba3_apb_sram_slave #(.WAIT_CYCLES(3)) u_dut2 (.pclk(pclk), .preset_n(preset_n), .apb(apb2));

  int waits_of[3] = '{0, 2, 3};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    t_psel = 1'b0;
    t_penable = 1'b0;
    repeat (n) begin
      @(posedge pclk); #1;
    end
  endtask

  // One transfer; returns when the completion edge has passed. With
  // corrupt set, paddr/pwdata/pwrite are disturbed after the first wait.
  task automatic xfer(input int sel, input logic wr, input addr_t a, input data_t d,
                      input logic corrupt, output data_t rd, output logic er, output int waits);
    bit done = 0;
    rd = '0; er = 1'b0; waits = 0;
    t_sel = sel; t_paddr = a; t_pwrite = wr; t_pwdata = d;
    t_psel = 1'b1; t_penable = 1'b0;
    @(negedge pclk);
    check("setup_pready", {63'd0, r_pready}, 64'd0);
    @(posedge pclk); #1;
    t_penable = 1'b1;
    while (!done) begin
      @(negedge pclk);
      if (r_pready) begin
        rd = r_prdata; er = r_pslverr; done = 1;
      end else begin
        waits++;
        if (waits > 40) begin
          check("xfer_timeout", 64'd1, 64'd0);
          done = 1;
        end
      end
      @(posedge pclk); #1;
      if (!done && corrupt && waits == 1) begin
        t_paddr  = t_paddr ^ addr_t'(4);
        t_pwdata = ~t_pwdata;
        t_pwrite = ~t_pwrite;
      end
    end
    t_psel = 1'b0;
    t_penable = 1'b0;
  endtask

  typedef struct {
    int    sel;
    logic  wr;
    addr_t addr;
    data_t wdata;
    data_t exp_rdata;
    logic  exp_err;
    int    exp_waits;
  } vec_t;

  data_t mdl [3][256];

  initial begin : main
    vec_t  vecs[$];
    data_t rd;
    logic  er;
    int    w;
    bit    seen;

    // back-to-back rows: each setup follows the previous completion directly
    vecs.push_back('{0, 1'b1, 32'h0040, 32'h80003333, 32'h0,        1'b0, 0});
    vecs.push_back('{0, 1'b0, 32'h0040, 32'h0,        32'h80003333, 1'b0, 0});
    vecs.push_back('{0, 1'b1, 32'h0000, 32'h0000A5A5, 32'h0,        1'b0, 0});
    vecs.push_back('{0, 1'b0, 32'h0402, 32'h0,        32'h0,        1'b1, 0});
    vecs.push_back('{0, 1'b1, 32'h0400, 32'hFFFFFFFF, 32'h0,        1'b1, 0});
    vecs.push_back('{0, 1'b0, 32'h0000, 32'h0,        32'h0000A5A5, 1'b0, 0});
    vecs.push_back('{0, 1'b1, 32'h0018, 32'h22446688, 32'h0,        1'b0, 0});
    vecs.push_back('{0, 1'b0, 32'h0018, 32'h0,        32'h22446688, 1'b0, 0});
    vecs.push_back('{2, 1'b1, 32'h0084, 32'h04400011, 32'h0,        1'b0, 3});
    vecs.push_back('{2, 1'b0, 32'h0084, 32'h0,        32'h04400011, 1'b0, 3});
    vecs.push_back('{2, 1'b0, 32'h0401, 32'h0,        32'h0,        1'b1, 3});
    vecs.push_back('{1, 1'b1, 32'h03FC, 32'h13579BDF, 32'h0,        1'b0, 2});
    vecs.push_back('{1, 1'b0, 32'h03FC, 32'h0,        32'h13579BDF, 1'b0, 2});
    vecs.push_back('{1, 1'b0, 32'h0400, 32'h0,        32'h0,        1'b1, 2});

    // reset state
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    for (int s = 0; s < 3; s++) begin
      t_sel = s; #1;
      check($sformatf("reset_pready%0d", s), {63'd0, r_pready}, 64'd0);
      check($sformatf("reset_pslverr%0d", s), {63'd0, r_pslverr}, 64'd0);
      check($sformatf("reset_prdata%0d", s), {32'd0, r_prdata}, 64'd0);
    end
    @(posedge pclk); #1;
    preset_n = 1'b1;
    idle(2);

    foreach (vecs[i]) begin
      xfer(vecs[i].sel, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0, rd, er, w);
      check($sformatf("vec%0d_prdata", i), {32'd0, rd}, {32'd0, vecs[i].exp_rdata});
      check($sformatf("vec%0d_pslverr", i), {63'd0, er}, {63'd0, vecs[i].exp_err});
      check($sformatf("vec%0d_waits", i), 64'(w), 64'(vecs[i].exp_waits));
    end
    idle(2);

    // penable high with no setup phase: must not respond
    t_sel = 0; t_psel = 1'b1; t_penable = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge pclk);
      if (r_pready) seen = 1;
      @(posedge pclk); #1;
    end
    check("no_setup_pready", {63'd0, seen}, 64'd0);
    idle(1);
    xfer(0, 1'b0, 32'h0040, 32'h0, 1'b0, rd, er, w);
    check("after_nosetup_read", {32'd0, rd}, 64'h80003333);

    // paddr/pwdata/pwrite change during ACCESS: latched values win
    xfer(1, 1'b1, 32'h0030, 32'hAAAA5555, 1'b1, rd, er, w);
    check("corrupt_waits", 64'(w), 64'd2);
    check("corrupt_pslverr", {63'd0, er}, 64'd0);
    xfer(1, 1'b0, 32'h0030, 32'h0, 1'b0, rd, er, w);
    check("corrupt_latched_word", {32'd0, rd}, 64'hAAAA5555);
    xfer(1, 1'b0, 32'h0034, 32'h0, 1'b0, rd, er, w);
    check("corrupt_other_word", {32'd0, rd}, 64'd0);

    // abort: psel dropped in ACCESS before pready
    t_sel = 2; t_paddr = 32'h0020; t_pwrite = 1'b1; t_pwdata = 32'h12345678;
    t_psel = 1'b1; t_penable = 1'b0;
    @(posedge pclk); #1;
    t_penable = 1'b1;
    @(negedge pclk);
    seen = r_pready;
    @(posedge pclk); #1;
    t_psel = 1'b0; t_penable = 1'b0;
    repeat (6) begin
      @(negedge pclk);
      if (r_pready) seen = 1;
      @(posedge pclk); #1;
    end
    check("abort_no_pready", {63'd0, seen}, 64'd0);
    xfer(2, 1'b0, 32'h0020, 32'h0, 1'b0, rd, er, w);
    check("abort_no_write", {32'd0, rd}, 64'd0);
    check("abort_next_waits", 64'(w), 64'd3);

    // reset asserted during ACCESS of a write, while pready is up
    t_sel = 1; t_paddr = 32'h0010; t_pwrite = 1'b1; t_pwdata = 32'hDEADBEEF;
    t_psel = 1'b1; t_penable = 1'b0;
    @(posedge pclk); #1;
    t_penable = 1'b1;
    w = 0;
    seen = 0;
    while (!seen && w < 40) begin
      @(negedge pclk);
      if (r_pready) seen = 1;
      else begin
        @(posedge pclk); #1;
        w++;
      end
    end
    check("rst_mid_reached_ready", {63'd0, seen}, 64'd1);
    preset_n = 1'b0;
    #1;
    check("rst_async_pready", {63'd0, r_pready}, 64'd0);
    check("rst_async_pslverr", {63'd0, r_pslverr}, 64'd0);
    @(posedge pclk); #1;
    t_psel = 1'b0; t_penable = 1'b0;
    @(posedge pclk); #1;
    preset_n = 1'b1;
    idle(1);
    xfer(1, 1'b0, 32'h0010, 32'h0, 1'b0, rd, er, w);
    check("rst_write_discarded", {32'd0, rd}, 64'd0);
    xfer(0, 1'b0, 32'h0040, 32'h0, 1'b0, rd, er, w);
    check("rst_mem_cleared", {32'd0, rd}, 64'd0);

    // randomized transfers against a word-array model (all cleared by reset)
    for (int s = 0; s < 3; s++)
      for (int k = 0; k < 256; k++) mdl[s][k] = '0;
    for (int n = 0; n < 1000; n++) begin
      int    sel, r;
      logic  wr, exp_err;
      addr_t a;
      data_t d, exp_rd;
      sel = $urandom_range(2);
      wr  = 1'($urandom_range(1));
      d   = $urandom;
      r   = $urandom_range(15);
      if (r == 0)      a = 32'h400 + 32'($urandom_range(63)) * 4;
      else if (r == 1) a = 32'($urandom_range(255)) * 4 + 32'($urandom_range(3, 1));
      else             a = 32'($urandom_range(31)) * 4;
      exp_err = !((a < 32'd1024) && (a % 4 == 0));
      exp_rd  = (!wr && !exp_err) ? mdl[sel][a / 4] : '0;
      xfer(sel, wr, a, d, 1'b0, rd, er, w);
      if (wr && !exp_err) mdl[sel][a / 4] = d;
      check($sformatf("rnd%0d_prdata", n), {32'd0, rd}, {32'd0, exp_rd});
      check($sformatf("rnd%0d_pslverr", n), {63'd0, er}, {63'd0, exp_err});
      check($sformatf("rnd%0d_waits", n), 64'(w), 64'(waits_of[sel]));
      if ($urandom_range(3) == 0) idle(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
